// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one full-subtractor
// cell iterated LSB first, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             busy_q;
    logic             done_q;
    logic             borrow_q;

    logic             x;
    logic             y;
    logic             d_d;
    logic             bo_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        x     = a_sh_q[0];
        y     = b_sh_q[0];
        d_d   = x ^ y ^ br_q;
        bo_d  = (~x & y) | (~x & br_q) | (y & br_q);
        res_d = {d_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    br_q   <= bo_d;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + 1'b1;
                    // Final bit: publish the assembled word straight from res_d so
                    // diff/borrow only ever change together with done.
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= bo_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner
// cases, exhaustive 4-bit sweep and a random 8-bit sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    int n_tests;
    int n_fail;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .bin    (bin4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .bin    (bin8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch one WIDTH=4 operation and wait (bounded) for its done pulse.
    task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       output logic [3:0] od, output logic ob, output int lat, output int bcnt);
        int k;
        bit seen;
        @(negedge clk);
        a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        k = 0; bcnt = 0; seen = 0; lat = -1; od = '0; ob = 1'b0;
        while (k < 40 && !seen) begin
            if (done4) begin
                seen = 1;
                lat  = k;
                od   = diff4;
                ob   = borrow4;
                check("busy_with_done4", {31'b0, busy4}, 0);
            end else begin
                if (busy4) bcnt++;
                @(negedge clk);
                k++;
            end
        end
        check("done4_seen", {31'b0, seen}, 1);
        if (seen) begin
            @(negedge clk);
            check("done4_one_cycle", {31'b0, done4}, 0);
        end
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output logic [7:0] od, output logic ob, output int lat);
        int k;
        bit seen;
        @(negedge clk);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = 0; seen = 0; lat = -1; od = '0; ob = 1'b0;
        while (k < 60 && !seen) begin
            if (done8) begin
                seen = 1;
                lat  = k;
                od   = diff8;
                ob   = borrow8;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("done8_seen", {31'b0, seen}, 1);
        if (seen) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] od;
        logic       ob;
        logic [7:0] od8;
        int         lat;
        int         bcnt;
        int         evts;
        logic [4:0] s5;
        logic [4:0] ad5;
        logic [3:0] ta;
        logic [3:0] tb;
        logic       tbin;
        logic [8:0] s9;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{a: 4'd5,  b: 4'd3,  bin: 1'b0, ed: 4'b0010, eb: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, ed: 4'b1110, eb: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, ed: 4'b1111, eb: 1'b1};
        vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, ed: 4'b0000, eb: 1'b0};
        vecs[4] = '{a: 4'd9,  b: 4'd2,  bin: 1'b0, ed: 4'b0111, eb: 1'b0};
        vecs[5] = '{a: 4'd12, b: 4'd4,  bin: 1'b0, ed: 4'b1000, eb: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd15, bin: 1'b0, ed: 4'b0001, eb: 1'b1};
        vecs[7] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, ed: 4'b1110, eb: 1'b0};
        vecs[8] = '{a: 4'd8,  b: 4'd8,  bin: 1'b1, ed: 4'b1111, eb: 1'b1};
        vecs[9] = '{a: 4'd7,  b: 4'd0,  bin: 1'b0, ed: 4'b0111, eb: 1'b0};

        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy4}, 0);
        check("rst_done", {31'b0, done4}, 0);
        check("rst_diff", {28'b0, diff4}, 0);
        check("rst_borrow", {31'b0, borrow4}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].bin, od, ob, lat, bcnt);
            check("tbl_diff", {28'b0, od}, {28'b0, vecs[i].ed});
            check("tbl_borrow", {31'b0, ob}, {31'b0, vecs[i].eb});
            check("tbl_latency", lat, 4);
            check("tbl_busy_cycles", bcnt, 4);
        end

        // start pulses during SHIFT and DONE must be ignored
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("ign_busy_k3", {31'b0, busy4}, 1);
        check("ign_done_k3", {31'b0, done4}, 0);
        @(negedge clk);
        check("ign_done_k4", {31'b0, done4}, 1);
        check("ign_diff", {28'b0, diff4}, 7);
        check("ign_borrow", {31'b0, borrow4}, 0);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("ign_done_k5", {31'b0, done4}, 0);
        check("ign_busy_k5", {31'b0, busy4}, 0);
        evts = 0;
        repeat (12) begin
            @(negedge clk);
            if (done4 || busy4) evts++;
        end
        check("ign_no_second_op", evts, 0);

        // reset mid-operation
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd4; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy4}, 0);
        check("mid_rst_done", {31'b0, done4}, 0);
        check("mid_rst_diff", {28'b0, diff4}, 0);
        check("mid_rst_borrow", {31'b0, borrow4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        evts = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4 || busy4) evts++;
        end
        check("post_rst_quiet", evts, 0);
        op4(4'd12, 4'd4, 1'b0, od, ob, lat, bcnt);
        check("post_rst_diff", {28'b0, od}, 8);
        check("post_rst_borrow", {31'b0, ob}, 0);

        // start held high: accepts at edges 0, 6, 12, ...; done seen at negedge i+5
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (i >= 5 && (i - 5) % 6 == 0) begin
                check("b2b_done_hi", {31'b0, done4}, 1);
                ta   = 4'((i - 5) * 7 + 3);
                tb   = 4'((i - 5) * 5 + 1);
                tbin = 1'((i - 5) % 2);
                s5   = {1'b0, ta} - {1'b0, tb} - {4'b0, tbin};
                check("b2b_diff", {28'b0, diff4}, {28'b0, s5[3:0]});
                check("b2b_borrow", {31'b0, borrow4}, {31'b0, s5[4]});
            end else begin
                check("b2b_done_lo", {31'b0, done4}, 0);
            end
            a4 = 4'(i * 7 + 3); b4 = 4'(i * 5 + 1); bin4 = 1'(i % 2); start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);

        // exhaustive WIDTH=4, checked against subtraction and the adder identity
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    ta   = 4'(ia);
                    tb   = 4'(ib);
                    tbin = 1'(ic);
                    op4(ta, tb, tbin, od, ob, lat, bcnt);
                    s5  = {1'b0, ta} - {1'b0, tb} - {4'b0, tbin};
                    ad5 = {1'b0, ta} + {1'b0, ~tb} + {4'b0, ~tbin};
                    check("exh_diff_sub", {28'b0, od}, {28'b0, s5[3:0]});
                    check("exh_borrow_sub", {31'b0, ob}, {31'b0, s5[4]});
                    check("exh_diff_add", {28'b0, od}, {28'b0, ad5[3:0]});
                    check("exh_borrow_add", {31'b0, ob}, {31'b0, ~ad5[4]});
                end
            end
        end

        // random WIDTH=8 sweep
        for (int n = 0; n < 64; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            op8(ra, rb, rc, od8, ob, lat);
            s9 = {1'b0, ra} - {1'b0, rb} - {8'b0, rc};
            check("w8_diff", {24'b0, od8}, {24'b0, s9[7:0]});
            check("w8_borrow", {31'b0, ob}, {31'b0, s9[8]});
            check("w8_latency", lat, 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
